// File: rtl/cfg_int_mc_pkg.sv
// rtl/cfg_int_mc_pkg.sv - shared constants and types for the codec configuration interface
package cfg_int_mc_pkg;

    localparam int CH_W        = 4;
    localparam int CH_EN_BIT   = 0;
    localparam int CH_LAW_BIT  = 1;
    localparam int CH_RATE_LSB = 2;
    localparam int CH_RATE_MSB = 3;

    typedef enum logic [1:0] {
        RATE_40K = 2'b00,
        RATE_32K = 2'b01,
        RATE_24K = 2'b10,
        RATE_16K = 2'b11
    } rate_e;

    typedef enum logic {
        LAW_MU = 1'b0,
        LAW_A  = 1'b1
    } law_e;

    localparam int GC_COMMIT_BIT  = 0;
    localparam int GC_CLEAR_BIT   = 1;
    localparam int GC_PAR_INV_BIT = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } host_state_e;

endpackage

// File: rtl/cfg_int_mc_chreg.sv
// rtl/cfg_int_mc_chreg.sv - one channel's shadow/active register pair (parity with CFG_INT_MC_PARITY_EN)
module cfg_int_mc_chreg
    import cfg_int_mc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_data,
    input  logic            clear,
    input  logic            commit,
`ifdef CFG_INT_MC_PARITY_EN
    input  logic            par_inv,
    output logic            par_bad,
`endif
    output logic [CH_W-1:0] shadow,
    output logic [CH_W-1:0] active
);

`ifdef CFG_INT_MC_PARITY_EN
    logic par;

    assign par_bad = par ^ (^shadow);

    // A corrupted shadow word never reaches the codec; the old active value is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
            par    <= 1'b0;
        end else begin
            if (commit && !par_bad) begin
                active <= shadow;
            end
            if (clear) begin
                shadow <= '0;
                par    <= 1'b0;
            end else if (wr_en) begin
                shadow <= wr_data;
                par    <= (^wr_data) ^ par_inv;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (commit) begin
                active <= shadow;
            end
            if (clear) begin
                shadow <= '0;
            end else if (wr_en) begin
                shadow <= wr_data;
            end
        end
    end
`endif

endmodule

// File: rtl/cfg_int_mc.sv
// rtl/cfg_int_mc.sv - multichannel codec config interface, frame-atomic commit (option CFG_INT_MC_PARITY_EN)
module cfg_int_mc
    import cfg_int_mc_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_sync,
    input  logic                   cfg_req,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [DATA_W-1:0]      cfg_wdata,
    output logic                   cfg_ack,
    output logic [DATA_W-1:0]      cfg_rdata,
    output logic                   cfg_err,
    output logic [NUM_CH*CH_W-1:0] ch_cfg,
    output logic                   commit_pending,
    output logic                   commit_done
`ifdef CFG_INT_MC_PARITY_EN
    ,
    output logic                   par_err
`endif
);

    host_state_e     state;
    logic            access;
    logic            addr_is_ch;
    logic            addr_is_gc;
    logic            ch_wr;
    logic            gc_wr;
    logic            commit_req;
    logic            clear_req;
    logic            apply;
    logic [CH_W-1:0] shadow_w [NUM_CH];
    logic [CH_W-1:0] rd_ch;
    logic            unused_wdata;

`ifdef CFG_INT_MC_PARITY_EN
    logic              par_arm;
    logic [NUM_CH-1:0] bad_vec;
    logic              rd_bad;
`endif

    assign access       = (state == ST_IDLE) && cfg_req;
    assign addr_is_ch   = cfg_addr < ADDR_W'(NUM_CH);
    assign addr_is_gc   = cfg_addr == ADDR_W'(NUM_CH);
    assign ch_wr        = access && cfg_we && addr_is_ch;
    assign gc_wr        = access && cfg_we && addr_is_gc;
    assign commit_req   = gc_wr && cfg_wdata[GC_COMMIT_BIT];
    assign clear_req    = gc_wr && cfg_wdata[GC_CLEAR_BIT];
    assign apply        = frame_sync && commit_pending;
    assign unused_wdata = ^cfg_wdata;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        cfg_int_mc_chreg u_chreg (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (ch_wr && (cfg_addr == ADDR_W'(k))),
            .wr_data (cfg_wdata[CH_W-1:0]),
            .clear   (clear_req),
            .commit  (apply),
`ifdef CFG_INT_MC_PARITY_EN
            .par_inv (par_arm),
            .par_bad (bad_vec[k]),
`endif
            .shadow  (shadow_w[k]),
            .active  (ch_cfg[k*CH_W +: CH_W])
        );
    end

    always_comb begin
        rd_ch = '0;
`ifdef CFG_INT_MC_PARITY_EN
        rd_bad = 1'b0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_addr == ADDR_W'(k)) begin
                rd_ch = shadow_w[k];
`ifdef CFG_INT_MC_PARITY_EN
                rd_bad = bad_vec[k];
`endif
            end
        end
    end

    // A commit write on an applying frame_sync re-arms for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cfg_ack        <= 1'b0;
            cfg_rdata      <= '0;
            cfg_err        <= 1'b0;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
`ifdef CFG_INT_MC_PARITY_EN
            par_err        <= 1'b0;
            par_arm        <= 1'b0;
`endif
        end else begin
            commit_done <= apply;
            if (commit_req) begin
                commit_pending <= 1'b1;
            end else if (apply) begin
                commit_pending <= 1'b0;
            end
`ifdef CFG_INT_MC_PARITY_EN
            if (apply && (|bad_vec)) begin
                par_err <= 1'b1;
            end
            if (gc_wr && cfg_wdata[GC_PAR_INV_BIT]) begin
                par_arm <= 1'b1;
            end else if (ch_wr) begin
                par_arm <= 1'b0;
            end
`endif
            case (state)
                ST_IDLE: begin
                    cfg_ack   <= 1'b0;
                    cfg_rdata <= '0;
                    cfg_err   <= 1'b0;
                    if (cfg_req) begin
                        state   <= ST_ACK;
                        cfg_ack <= 1'b1;
                        if (addr_is_ch) begin
                            cfg_rdata <= cfg_we ? '0 : DATA_W'(rd_ch);
`ifdef CFG_INT_MC_PARITY_EN
                            cfg_err   <= !cfg_we && rd_bad;
`endif
                        end else if (addr_is_gc) begin
                            cfg_rdata <= cfg_we ? '0 : DATA_W'(commit_pending);
                        end else begin
                            cfg_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cfg_ack   <= 1'b0;
                    cfg_rdata <= '0;
                    cfg_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_int_mc.sv
// tb/tb_cfg_int_mc.sv - scoreboard bench for cfg_int_mc (parity cases with CFG_INT_MC_PARITY_EN)
module tb_cfg_int_mc;

    localparam int NUM_CH = 32;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
`ifdef CFG_INT_MC_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  frame_sync = 1'b0;
    logic                  cfg_req = 1'b0;
    logic                  cfg_we = 1'b0;
    logic [ADDR_W-1:0]     cfg_addr = '0;
    logic [DATA_W-1:0]     cfg_wdata = '0;
    logic                  cfg_ack;
    logic [DATA_W-1:0]     cfg_rdata;
    logic                  cfg_err;
    logic [NUM_CH*4-1:0]   ch_cfg;
    logic                  commit_pending;
    logic                  commit_done;
`ifdef CFG_INT_MC_PARITY_EN
    logic                  par_err;
`endif

    cfg_int_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_sync     (frame_sync),
        .cfg_req        (cfg_req),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_ack        (cfg_ack),
        .cfg_rdata      (cfg_rdata),
        .cfg_err        (cfg_err),
        .ch_cfg         (ch_cfg),
        .commit_pending (commit_pending),
        .commit_done    (commit_done)
`ifdef CFG_INT_MC_PARITY_EN
        ,
        .par_err        (par_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t     exp_q[$];
    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    bit       mon_en = 1'b0;

    // Reference model: what the host has written and what the codecs currently see.
    logic [3:0] m_shadow [NUM_CH];
    logic [3:0] m_active [NUM_CH];
    bit         m_bad    [NUM_CH];
    bit         m_pend, m_done, m_arm, m_par_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i*4 +: 4] = m_active[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_shadow[i] = 4'h0;
            m_active[i] = 4'h0;
            m_bad[i]    = 1'b0;
        end
        m_pend = 0; m_done = 0; m_arm = 0; m_par_err = 0;
    endtask

    task automatic step(input bit req, input bit acc, input bit we, input logic [6:0] addr,
                        input logic [7:0] wdata, input bit fs, input bit rst);
        exp_t e;
        bit   apply;
        int   a;
        @(negedge clk);
        reset = rst; cfg_req = req; cfg_we = we; cfg_addr = addr; cfg_wdata = wdata; frame_sync = fs;
        @(posedge clk);
        a = int'(addr);
        if (rst) begin
            model_reset();
        end else begin
            apply = fs && m_pend;
            if (acc) begin
                e.cyc = cyc + 1; e.rdata = 8'h00; e.err = 1'b0;
                if (a < NUM_CH) begin
                    if (!we) begin
                        e.rdata = {4'h0, m_shadow[a]};
                        e.err   = m_bad[a];
                    end
                end else if (a == NUM_CH) begin
                    if (!we) e.rdata = {7'h0, m_pend};
                end else begin
                    e.err = 1'b1;
                end
                exp_q.push_back(e);
            end
            if (apply) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_bad[i]) m_par_err = 1'b1;
                    else m_active[i] = m_shadow[i];
                end
                m_pend = 1'b0;
            end
            if (acc && we) begin
                if (a < NUM_CH) begin
                    m_shadow[a] = wdata[3:0];
                    m_bad[a]    = m_arm;
                    m_arm       = 1'b0;
                end else if (a == NUM_CH) begin
                    if (wdata[0]) m_pend = 1'b1;
                    if (wdata[1]) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            m_shadow[i] = 4'h0;
                            m_bad[i]    = 1'b0;
                        end
                    end
                    if (wdata[2]) m_arm = PAR_EN;
                end
            end
            m_done = apply;
        end
    endtask

    task automatic tx(input bit we, input logic [6:0] addr, input logic [7:0] wdata, input bit fs0, input bit fs1);
        step(1'b1, 1'b1, we, addr, wdata, fs0, 1'b0);
        step(1'b1, 1'b0, we, addr, wdata, fs1, 1'b0);
    endtask

    task automatic idle(input bit fs);
        step(1'b0, 1'b0, 1'b0, 7'd0, 8'h00, fs, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (cfg_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 128'(cfg_ack), 128'(1'b0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_cycle", 128'(cyc), 128'(e.cyc));
                    chk("rdata", 128'(cfg_rdata), 128'(e.rdata));
                    chk("err", 128'(cfg_err), 128'(e.err));
                end
            end else begin
                chk("idle_rdata_err", {119'h0, cfg_rdata, cfg_err}, 128'h0);
            end
            chk("ch_cfg", ch_cfg, model_vec());
            chk("commit_pending", 128'(commit_pending), 128'(m_pend));
            chk("commit_done", 128'(commit_done), 128'(m_done));
`ifdef CFG_INT_MC_PARITY_EN
            chk("par_err", 128'(par_err), 128'(m_par_err));
`endif
        end
    end

    initial begin
        logic [7:0] d;
        int         r;
        logic [6:0] ad;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1);
        mon_en = 1'b1;

        tx(1'b0, 7'd5, 8'h00, 1'b0, 1'b0);
        tx(1'b1, 7'd3, 8'h0B, 1'b0, 1'b0);
        tx(1'b1, 7'd32, 8'h01, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        #2 chk("tp2_ch3_active", 128'(ch_cfg[15:12]), 128'(4'hB));

        tx(1'b1, 7'd3, 8'h05, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        #2 chk("tp3_ch3_held", 128'(ch_cfg[15:12]), 128'(4'hB));
        tx(1'b0, 7'd3, 8'h00, 1'b0, 1'b0);

        tx(1'b1, 7'd32, 8'h01, 1'b1, 1'b0);
        #2 chk("tp4_no_update", 128'(ch_cfg[15:12]), 128'(4'hB));
        idle(1'b1);
        #2 chk("tp4_next_frame", 128'(ch_cfg[15:12]), 128'(4'h5));

        tx(1'b0, 7'd100, 8'h00, 1'b0, 1'b0);
        tx(1'b1, 7'd33, 8'hFF, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom_range(0, 255));
            if (r < 6) begin
                ad = 7'($urandom_range(0, NUM_CH - 1));
            end else if (r < 8) begin
                ad = 7'(NUM_CH);
                d  = (d & 8'hFD) | (($urandom_range(0, 7) == 0) ? 8'h02 : 8'h00);
            end else if (r == 8) begin
                ad = 7'($urandom_range(NUM_CH + 1, 127));
            end else begin
                ad = 7'(NUM_CH);
            end
            tx(1'($urandom_range(0, 1)), ad, d, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3) == 0);
            if (n == 200) begin
                step(1'b1, 1'b0, 1'b0, 7'd5, 8'h00, 1'b0, 1'b1);
                idle(1'b0);
            end
        end

        step(1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1);
        tx(1'b1, 7'd32, 8'h04, 1'b0, 1'b0);
        tx(1'b1, 7'd7, 8'h03, 1'b0, 1'b0);
        tx(1'b0, 7'd7, 8'h00, 1'b0, 1'b0);
        tx(1'b1, 7'd6, 8'h09, 1'b0, 1'b0);
        tx(1'b1, 7'd32, 8'h01, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        #2 chk("tp6_ch6_active", 128'(ch_cfg[27:24]), 128'(4'h9));
        chk("tp6_ch7_active", 128'(ch_cfg[31:28]), PAR_EN ? 128'h0 : 128'h3);
`ifdef CFG_INT_MC_PARITY_EN
        chk("tp6_par_err", 128'(par_err), 128'h1);
`endif

        idle(1'b0);
        idle(1'b0);
        chk("scoreboard_drain", 128'(exp_q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_int_mc.md
Name: cfg_int_mc

Overview:
Parametrised multichannel configuration interface for the ADPCM codec array. A simple host request/acknowledge port writes per-channel shadow registers. All shadow registers are committed atomically into active registers on the next frame_sync after a commit request. Codec channels therefore never see a half-updated configuration mid-frame.

Parameters:
NUM_CH, 32, number of codec channels (1..64)
ADDR_W, 7, host address width; must satisfy 2**ADDR_W > NUM_CH
DATA_W, 8, host data width; must be >= CH_W (4)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
frame_sync  in  1  one-cycle pulse at each 125 us frame boundary
cfg_req  in  1  host request; held high until cfg_ack
cfg_we  in  1  1 = write, 0 = read; sampled with cfg_req
cfg_addr  in  ADDR_W  register address
cfg_wdata  in  DATA_W  write data
cfg_ack  out  1  one-cycle transaction complete
cfg_rdata  out  DATA_W  read data; valid only with cfg_ack, 0 otherwise
cfg_err  out  1  with cfg_ack: address out of range (or parity error, see Optional Feature)
ch_cfg  out  NUM_CH*CH_W  active config, channel k at bits [k*4+3:k*4]
commit_pending  out  1  commit requested, not yet applied
commit_done  out  1  one-cycle pulse in the cycle after active registers update

Behaviour:
- Channel word (CH_W=4): bit0 enable, bit1 law (0 = mu-law, 1 = A-law), bits[3:2] rate (00=40k, 01=32k, 10=24k, 11=16k).
- Address map:
  - 0..NUM_CH-1: channel shadow, read/write. Writes take cfg_wdata[3:0]; reads return the shadow word zero-extended.
  - NUM_CH: global control. Write bit0=1 requests commit; write bit1=1 clears all shadows to 0. Read returns {0.., commit_pending}.
  - Addresses above NUM_CH: writes ignored; reads return 0; cfg_err=1 with cfg_ack.
- Host FSM states: IDLE, ACK.
  - IDLE -> ACK when cfg_req=1. The register access is performed on that edge.
  - ACK drives cfg_ack=1 for one cycle, then returns to IDLE.
  - Latency: request in cycle n gives ack in cycle n+1.
  - cfg_req still high in the IDLE cycle after an ack is a new transaction. Maximum throughput is one transaction per 2 cycles.
- Commit:
  - A write of bit0 sets commit_pending.
  - On frame_sync with commit_pending=1: active <= shadow for all channels, commit_pending <= 0. commit_done pulses the next cycle.
  - frame_sync with commit_pending=0 has no effect.
- Simultaneous events:
  - Commit write on the same edge as frame_sync: the commit applies at the following frame_sync, not this one.
  - Channel write on the same edge as a commit-applying frame_sync: active takes the pre-write shadow; the new value stays in shadow.
  - Shadow-clear write with commit_pending=1: commit_pending stays set.
- Reset: shadow=0, active=0 (all channels disabled), FSM=IDLE, all outputs 0. Reset mid-transaction aborts it; no ack is issued.

Optional Feature:
Macro CFG_INT_MC_PARITY_EN.
- Enabled:
  - Each shadow word stores an even-parity bit computed on write.
  - Global control write bit2=1 arms single-shot parity inversion on the next channel write.
  - Reading a channel with bad parity gives cfg_err=1 with cfg_ack.
  - On commit, a channel with bad parity keeps its old active value. Sticky output par_err (1 bit, cleared only by reset) is set.
- Disabled: no parity storage, no par_err port, bit2 ignored.

Decomposition:
Package cfg_int_mc_pkg holds:
- CH_W=4 and the channel field bit positions;
- rate encodings and law encodings;
- global control bit positions;
- FSM state enum.
One natural sub-module, cfg_int_mc_chreg: the per-channel shadow/active register pair (plus parity), instantiated NUM_CH times by generate.

Test Plan:
1. Reset, then read addr 5 -> ack one cycle after req, rdata=0x00, err=0; ch_cfg all 0.
2. Write addr 3 = 0x0B, write addr 32 = 0x01, pulse frame_sync -> ch_cfg[15:12]=0xB, commit_pending 1->0, commit_done pulses one cycle later; other channels stay 0.
3. Write addr 3 = 0x05 without commit, pulse frame_sync twice -> ch_cfg[15:12] stays 0xB; read addr 3 returns 0x05.
4. Commit write coincident with frame_sync -> no update that frame; update at next frame_sync.
5. Read addr 100 -> rdata=0, err=1; write addr 33 = 0xFF -> ack with err=1, no state change.
6. Parity build: write addr 32 = 0x04, write addr 7 = 0x03, read addr 7 -> err=1. Commit -> ch_cfg[31:28] unchanged, par_err=1.
